prioritized_request_stage: RTL
==============================

Name: prioritized_request_stage

Overview:
Upstream stage for prioritized_arbiter. It captures one request per input through a valid/ready handshake and holds it in a one-entry slot. It drives the arbiter's data[] and selection[] arrays and locks the current winner stable until a downstream consumer accepts it. The winning slot is then cleared and the next winner is locked, so a combinational arbiter becomes a flow-controlled N:1 stage.

Parameters:
data_width, 8, width of each request payload
number_of_inputs, 4, number of request slots (must be at least 2)
priority_list, '{0, 2, 1, 3}, input indices ordered low to high priority. The leftmost entry is priority_list[number_of_inputs-1] and is lowest priority; priority_list[0] is highest. The same value is passed to prioritized_arbiter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1 x number_of_inputs (unpacked)  request present on input i
in_data  input  data_width x number_of_inputs (unpacked)  request payload for input i
in_ready  output  1 x number_of_inputs (unpacked)  slot i can accept a request
data  output  data_width x number_of_inputs (unpacked)  slot payloads, to arbiter data[]
selection  output  1 x number_of_inputs (unpacked)  eligible mask, to arbiter selection[]
out_valid  output  1  a locked winner is presented
out_ready  input  1  downstream accepts the winner
out_index  output  max(1,$clog2(number_of_inputs))  index of the locked winner
out_data  output  data_width  payload of the locked winner; equals the arbiter's demuxed_data

Behaviour:
- Reset (rst_n low, asynchronous):
  - full[] = 0 and all slot data = 0.
  - state = IDLE, out_valid = 0, out_index = 0.
  - in_ready[] is forced to 0 while rst_n is low.
- Slot fill:
  - in_ready[i] = ~full[i] | drain[i], where drain[i] = out_valid & out_ready & (out_index == i).
  - When in_valid[i] & in_ready[i] at edge t, the slot captures in_data[i] and full[i] = 1 from t+1.
- Winner function win(m): the highest-priority index in mask m according to priority_list.
- State IDLE:
  - out_valid = 0 and selection = full[].
  - If |full at an edge: lock = win(full), go to HOLD.
  - Latency: request accepted at t, out_valid at t+2.
- State HOLD:
  - out_valid = 1 and out_index = lock.
  - selection = one-hot(lock), so the arbiter output stays on the locked slot.
  - A higher-priority arrival never preempts a locked winner.
  - out_data and out_index are stable while out_valid & ~out_ready.
- Accept (out_valid & out_ready at edge t):
  - Clear full[lock].
  - Let r = full & ~one-hot(lock), sampled before this edge's fills.
  - If r != 0: lock = win(r) and stay in HOLD, giving back-to-back grants with no bubble.
  - Otherwise go to IDLE.
- Same-cycle refill: a drained slot may be refilled at the same edge. The new request is eligible only from the next decision onward.
- Simultaneous fills on several inputs are all captured at the same edge.
- data[i] always shows slot i's register contents, including slots that are not full.
- A reset mid-operation drops all pending requests. No output glitches to a stale winner after rst_n deasserts.
- Elaboration assertion: priority_list must be a permutation of 0..number_of_inputs-1.
- Implementation note: win() is a for-loop over priority_list. Do not hardcode the order.

Test Plan:
- Reset with in_valid all 1 -> in_ready all 0 and out_valid 0. After release, in_ready becomes all 1 on the first cycle.
- Load slot1=3 and slot3=7 at the same edge, out_ready=0 -> out_valid at t+2 with out_index=3, out_data=7, selection=0b1000. Values are stable for 5 cycles.
- Continue the previous case with out_ready=1 -> next cycle out_index=1, out_data=3. After the following edge, out_valid=0 and state is IDLE.
- Lock slot 2 (data 5), then load slot 3 (data 7) while stalled -> out stays index 2 / data 5 until accepted, then index 3.
- Hold out_ready=1 while refilling slot 0 on every accept, with slot 2 kept pending -> service order 2 then 0. Slot 0 is accepted again at the same edge it drains, with no lost or duplicated payloads.
- Assert rst_n low while in HOLD with 3 slots full -> out_valid and full[] clear immediately (asynchronously). After release, out_valid stays 0 until new requests arrive.

Source files
------------

// File: rtl/prioritized_request_stage.sv
// Flow-controlled front end for prioritized_arbiter: one-entry request slots per input,
// plus a locked winner that stays presented until a downstream consumer accepts it.
module prioritized_request_stage #(
   parameter int data_width       = 8,
   parameter int number_of_inputs = 4,
   parameter int priority_list [number_of_inputs-1:0] = '{0, 2, 1, 3},
   localparam int index_width     = (number_of_inputs > 1) ? $clog2(number_of_inputs) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid  [number_of_inputs],
   input  logic [data_width-1:0]  in_data   [number_of_inputs],
   output logic                   in_ready  [number_of_inputs],
   output logic [data_width-1:0]  data      [number_of_inputs],
   output logic                   selection [number_of_inputs],
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [index_width-1:0] out_index,
   output logic [data_width-1:0]  out_data
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                  state_reg, state_next;
   logic [index_width-1:0]  lock_reg, lock_next;
   logic [number_of_inputs-1:0] full_reg, full_next;
   logic [number_of_inputs-1:0] fill, drain, lock_onehot, remaining;
   logic [data_width-1:0]   slot_data_reg [number_of_inputs];

   // priority_list must name every input exactly once.
   function automatic bit priority_list_ok();
      logic [number_of_inputs-1:0] seen;
      seen = '0;
      for (int p = 0; p < number_of_inputs; p++) begin
         if (priority_list[p] < 0 || priority_list[p] >= number_of_inputs)
            return 1'b0;
         seen[index_width'(priority_list[p])] = 1'b1;
      end
      return &seen;
   endfunction

   generate
      if (!priority_list_ok()) begin : g_priority_check
         $error("priority_list must be a permutation of 0..number_of_inputs-1");
      end
   endgenerate

   // Walk from lowest to highest priority so the highest set entry is the last write.
   function automatic logic [index_width-1:0] win(input logic [number_of_inputs-1:0] m);
      logic [index_width-1:0] w;
      w = '0;
      for (int p = number_of_inputs - 1; p >= 0; p--) begin
         if (m[index_width'(priority_list[p])])
            w = index_width'(priority_list[p]);
      end
      return w;
   endfunction

   assign out_valid   = (state_reg == HOLD);
   assign out_index   = lock_reg;
   assign out_data    = slot_data_reg[lock_reg];
   assign lock_onehot = number_of_inputs'(1) << lock_reg;
   // Candidates for the next back-to-back grant exclude same-edge refills.
   assign remaining   = full_reg & ~lock_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < number_of_inputs; gi++) begin : g_slot
         assign drain[gi]     = out_valid & out_ready & lock_onehot[gi];
         assign in_ready[gi]  = rst_n & (~full_reg[gi] | drain[gi]);
         assign fill[gi]      = in_valid[gi] & in_ready[gi];
         assign full_next[gi] = fill[gi] | (full_reg[gi] & ~drain[gi]);
         assign data[gi]      = slot_data_reg[gi];
         assign selection[gi] = out_valid ? lock_onehot[gi] : full_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_reg <= '0;
         for (int i = 0; i < number_of_inputs; i++)
            slot_data_reg[i] <= '0;
      end else begin
         full_reg <= full_next;
         for (int i = 0; i < number_of_inputs; i++)
            if (fill[i])
               slot_data_reg[i] <= in_data[i];
      end
   end

   always_comb begin
      state_next = state_reg;
      lock_next  = lock_reg;
      case (state_reg)
         IDLE: begin
            if (|full_reg) begin
               lock_next  = win(full_reg);
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (|remaining)
                  lock_next = win(remaining);
               else
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         lock_reg  <= '0;
      end else begin
         state_reg <= state_next;
         lock_reg  <= lock_next;
      end
   end

endmodule
